samp_ram_tdp: RTL and testbench
===============================

# samp_ram_tdp

Parametrised single-clock true dual-port sample RAM for the waveform generator, successor to the fixed 1024x16 sample store. Adds per-port enables, selectable write mode, configurable read latency, registered write-write collision reporting and an optional post-reset clear engine. It sits between the command parser, which writes samples on port A, and the sample playback engine, which reads on port B; either port may read or write.

## Interface
- DATA_WIDTH, 16, sample word width (1..64)
- ADDR_WIDTH, 10, address width; depth = 2**ADDR_WIDTH
- READ_LATENCY, 1, clock edges from address to dout; legal values 1 or 2
- WRITE_MODE, 0, same-port write behaviour: 0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE
- clk  in  1  single clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- ena  in  1  port A enable; when low, port A ignores wea/addra and holds douta
- wea  in  1  port A write enable (qualified by ena)
- addra  in  ADDR_WIDTH  port A address
- dina  in  DATA_WIDTH  port A write data
- douta  out  DATA_WIDTH  port A read data
- enb  in  1  port B enable
- web  in  1  port B write enable (qualified by enb)
- addrb  in  ADDR_WIDTH  port B address
- dinb  in  DATA_WIDTH  port B write data
- doutb  out  DATA_WIDTH  port B read data
- collision  out  1  one-cycle pulse: both ports wrote the same address
- busy  out  1  clear engine active; port accesses ignored

## Operation
- Port access occurs on a rising clk when en=1 and busy=0.
- Write (en=1, we=1): mem[addr] <= din. Stage-1 output per WRITE_MODE: WRITE_FIRST loads din; READ_FIRST loads old mem[addr]; NO_CHANGE holds previous value.
- Read (en=1, we=0): stage-1 output loads mem[addr].
- en=0: stage-1 output holds; memory untouched.
- Cross-port, same address, same edge:
  - A writes, B reads: B gets old contents (read-before-write), regardless of WRITE_MODE.
  - Both write: port A data is stored, port B write discarded; collision=1 on the following cycle. Port B stage-1 output still follows WRITE_MODE using dinb/old data, as if its write had occurred.
  - Both read: both get mem[addr].
- collision evaluated only when busy=0; never asserted for differing addresses or single-port writes.
- READ_LATENCY=2: an unconditional second register follows stage 1 on each port (advances every cycle, not gated by en).
- Reset: douta, doutb, pipeline registers = 0; collision = 0; memory contents not reset by rst (see Configuration).

## Timing
- READ_LATENCY=1: addr sampled at edge N, dout valid after edge N.
- READ_LATENCY=2: dout valid after edge N+1.
- collision: registered; high for exactly the cycle after edge N of the double write.
- Back-to-back accesses every cycle on both ports supported; no stalls except busy.
- rst asserted mid-operation: outputs clear immediately (asynchronously); an in-flight write on the asserting edge is not guaranteed; clear engine, if compiled, restarts at address 0.

## Configuration
- SAMP_RAM_INIT_CLEAR_EN defined: on rst deassertion busy=1 (busy also 1 during rst). A counter writes 0 to addresses 0..2**ADDR_WIDTH-1, one per cycle. busy falls after the final write, exactly 2**ADDR_WIDTH cycles after the first clk edge with rst low. During busy, en/we are ignored, dout holds 0 and collision stays 0.
- Undefined: busy tied 0, no counter; memory content after power-up is undefined and rst does not alter it.

## Test plan
- WRITE_MODE=0, LAT=1: A writes 0x1234 @0x005; next cycle B reads 0x005 -> doutb=0x1234 one edge later; douta=0x1234 on the write edge.
- WRITE_MODE=1: preload 0x00AA @0x010; A writes 0x5555 @0x010 -> douta=0x00AA; following read -> 0x5555.
- Same edge A writes 0xBEEF, B writes 0xDEAD @0x3FF -> collision=1 for one cycle; later read @0x3FF -> 0xBEEF.
- A writes 0x0F0F @0x020 while B reads 0x020 (old 0x0001) -> doutb=0x0001; next B read -> 0x0F0F.
- LAT=2: B reads 0x005 at edge N -> doutb updates after N+1, not after N; enb=0 for 3 cycles holds value.
- SAMP_RAM_INIT_CLEAR_EN, ADDR_WIDTH=4: write 0xFFFF everywhere, pulse rst -> busy high 16 cycles, writes during busy ignored, all 16 reads return 0x0000; rst pulsed at cycle 8 restarts the full 16-cycle clear.

Source files
------------

// File: rtl/samp_ram_tdp.sv
// Single-clock true dual-port sample RAM: port A (parser) and port B (playback), per-port enable, write mode, 1/2-cycle read latency.
// Optional post-reset zero-fill engine compiled in with SAMP_RAM_INIT_CLEAR_EN; without it busy is tied low.
module samp_ram_tdp #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    input  logic                  enb,
    input  logic                  web,
    input  logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] dinb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  collision,
    output logic                  busy
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  busy_w;
    logic                  clr_wr;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  acc_a, acc_b;
    logic                  wr_a, wr_b;
    logic [DATA_WIDTH-1:0] rd_a, rd_b;
    logic [DATA_WIDTH-1:0] s1a_q, s1a_d, s1b_q, s1b_d;
    logic                  coll_q, coll_d;

`ifdef SAMP_RAM_INIT_CLEAR_EN
    logic                  clr_busy_q, clr_busy_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

    always_comb begin
        clr_busy_d = clr_busy_q;
        clr_addr_d = clr_addr_q;
        if (clr_busy_q) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (&clr_addr_q) begin
                clr_busy_d = 1'b0;
            end
        end
    end

    // Reset value 1 keeps busy high while rst is asserted and restarts the sweep at address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_busy_q <= 1'b1;
            clr_addr_q <= '0;
        end else begin
            clr_busy_q <= clr_busy_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign busy_w   = clr_busy_q;
    assign clr_wr   = clr_busy_q & ~rst;
    assign clr_addr = clr_addr_q;
`else
    assign busy_w   = 1'b0;
    assign clr_wr   = 1'b0;
    assign clr_addr = '0;
`endif

    assign busy  = busy_w;
    assign acc_a = ena & ~busy_w & ~rst;
    assign acc_b = enb & ~busy_w & ~rst;
    assign wr_a  = acc_a & wea;
    assign wr_b  = acc_b & web;
    assign rd_a  = mem[addra];
    assign rd_b  = mem[addrb];

    // Port A write is issued last so it wins a same-address double write.
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wr_b) begin
                mem[addrb] <= dinb;
            end
            if (wr_a) begin
                mem[addra] <= dina;
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] stage1_next(
        input logic                  acc,
        input logic                  we,
        input logic [DATA_WIDTH-1:0] din,
        input logic [DATA_WIDTH-1:0] rd,
        input logic [DATA_WIDTH-1:0] cur
    );
        stage1_next = cur;
        if (acc) begin
            if (!we || WRITE_MODE == 1) begin
                stage1_next = rd;
            end else if (WRITE_MODE == 0) begin
                stage1_next = din;
            end
        end
    endfunction

    // rd_a/rd_b see pre-edge contents, giving read-before-write across ports.
    always_comb begin
        s1a_d  = stage1_next(acc_a, wea, dina, rd_a, s1a_q);
        s1b_d  = stage1_next(acc_b, web, dinb, rd_b, s1b_q);
        coll_d = wr_a & wr_b & (addra == addrb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1a_q  <= '0;
            s1b_q  <= '0;
            coll_q <= 1'b0;
        end else begin
            s1a_q  <= s1a_d;
            s1b_q  <= s1b_d;
            coll_q <= coll_d;
        end
    end

    assign collision = coll_q;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] s2a_q, s2b_q;

            // Output register runs every cycle; only stage 1 honours the enables.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2a_q <= '0;
                    s2b_q <= '0;
                end else begin
                    s2a_q <= s1a_q;
                    s2b_q <= s1b_q;
                end
            end

            assign douta = s2a_q;
            assign doutb = s2b_q;
        end else begin : g_lat1
            assign douta = s1a_q;
            assign doutb = s1b_q;
        end
    endgenerate

endmodule

// File: tb/tb_samp_ram_tdp.sv
// Bench for samp_ram_tdp: three 1024x16 instances (write-first/lat1, read-first/lat1, no-change/lat2) share stimulus
// against an array model; a 16-deep instance exercises the clear engine when SAMP_RAM_INIT_CLEAR_EN is defined.
module tb_samp_ram_tdp;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, ena, wea, enb, web;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dina, dinb;
    logic [DW-1:0] douta_w [NI];
    logic [DW-1:0] doutb_w [NI];
    logic          coll_w  [NI];
    logic          busy_w  [NI];
    logic [DW-1:0] douta3, doutb3;
    logic          coll3, busy3;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        samp_ram_tdp #(
            .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
            .READ_LATENCY(g == 2 ? 2 : 1), .WRITE_MODE(g)
        ) u_dut (
            .clk(clk), .rst(rst),
            .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_w[g]),
            .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb_w[g]),
            .collision(coll_w[g]), .busy(busy_w[g])
        );
    end

    samp_ram_tdp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(4), .READ_LATENCY(1), .WRITE_MODE(0)
    ) u_small (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .addra(addra[3:0]), .dina(dina), .douta(douta3),
        .enb(enb), .web(web), .addrb(addrb[3:0]), .dinb(dinb), .doutb(doutb3),
        .collision(coll3), .busy(busy3)
    );

    // Reference model: memory with per-word known flags, per-instance output pipelines.
    logic [DW-1:0] mm [1<<AW];
    bit            mk [1<<AW];
    logic [DW-1:0] s1a [NI], s1b [NI], s2a [NI], s2b [NI];
    bit            k1a [NI], k1b [NI], k2a [NI], k2b [NI];
    bit            coll_m;
    int            n_cmp = 0;
    int            n_bad = 0;

    typedef struct {
        bit ena; bit wea; logic [AW-1:0] addra; logic [DW-1:0] dina;
        bit enb; bit web; logic [AW-1:0] addrb; logic [DW-1:0] dinb;
        bit cka; logic [DW-1:0] xa; bit ckb; logic [DW-1:0] xb; bit xcoll;
    } vec_t;
    vec_t tv [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit ea, input bit wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                         input bit eb, input bit wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        ena = ea; wea = wa; addra = aa; dina = da;
        enb = eb; web = wb; addrb = ab; dinb = db;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            s1a[i] = '0; s1b[i] = '0; s2a[i] = '0; s2b[i] = '0;
            k1a[i] = 1;  k1b[i] = 1;  k2a[i] = 1;  k2b[i] = 1;
        end
        coll_m = 0;
    endtask

    // Instance i: mode 0 write-first, 1 read-first, 2 no-change.
    task automatic model_edge();
        logic [DW-1:0] old_a, old_b;
        bit            oka, okb;
        old_a = mm[addra]; oka = mk[addra];
        old_b = mm[addrb]; okb = mk[addrb];
        for (int i = 0; i < NI; i++) begin
            s2a[i] = s1a[i]; k2a[i] = k1a[i];
            s2b[i] = s1b[i]; k2b[i] = k1b[i];
            if (ena) begin
                if (!wea || i == 1) begin s1a[i] = old_a; k1a[i] = oka; end
                else if (i == 0)    begin s1a[i] = dina;  k1a[i] = 1;   end
            end
            if (enb) begin
                if (!web || i == 1) begin s1b[i] = old_b; k1b[i] = okb; end
                else if (i == 0)    begin s1b[i] = dinb;  k1b[i] = 1;   end
            end
        end
        coll_m = ena && wea && enb && web && (addra == addrb);
        if (enb && web) begin mm[addrb] = dinb; mk[addrb] = 1; end
        if (ena && wea) begin mm[addra] = dina; mk[addra] = 1; end
    endtask

    task automatic check_model();
        for (int i = 0; i < NI; i++) begin
            if (i == 2 ? k2a[i] : k1a[i])
                chk($sformatf("douta[%0d]", i), douta_w[i], i == 2 ? s2a[i] : s1a[i]);
            if (i == 2 ? k2b[i] : k1b[i])
                chk($sformatf("doutb[%0d]", i), doutb_w[i], i == 2 ? s2b[i] : s1b[i]);
            chk($sformatf("collision[%0d]", i), coll_w[i], coll_m);
            chk($sformatf("busy[%0d]", i), busy_w[i], 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    // Called at a negedge right after rst is released.
    task automatic post_reset();
`ifdef SAMP_RAM_INIT_CLEAR_EN
        int n;
        n = 0;
        while (busy_w[0] && n < 2000) begin
            @(posedge clk); @(negedge clk); n++;
        end
        chk("clear_done_1024", n, 1 << AW);
        for (int j = 0; j < (1 << AW); j++) begin mm[j] = '0; mk[j] = 1; end
`endif
    endtask

`ifdef SAMP_RAM_INIT_CLEAR_EN
    task automatic fill_small();
        for (int j = 0; j < 16; j++) begin
            drive(1, 1, AW'(j), 16'hFFFF, 0, 0, '0, '0);
            @(posedge clk); @(negedge clk);
        end
        drive(1, 0, 10'h005, '0, 0, 0, '0, '0);
        @(posedge clk); @(negedge clk);
        chk("small_prefill", douta3, 16'hFFFF);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    // Hammers both ports while busy; returns edges until busy falls.
    task automatic clear_count(input int limit, output int n);
        n = 0;
        while (busy3 && n < limit) begin
            addra = AW'($urandom_range(0, 15));
            drive(1, 1, addra, 16'hABCD, 1, 1, addra, 16'h1357);
            @(posedge clk); @(negedge clk);
            n++;
            chk("busy_douta", douta3, 0);
            chk("busy_collision", coll3, 0);
        end
        drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic read_all_small(input string nm);
        for (int j = 0; j < 16; j++) begin
            drive(1, 0, AW'(j), '0, 1, 0, AW'(15 - j), '0);
            @(posedge clk); @(negedge clk);
            chk($sformatf("%s_a%0d", nm, j), douta3, 0);
            chk($sformatf("%s_b%0d", nm, 15 - j), doutb3, 0);
        end
        drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask
`endif

    initial begin
        int n;
        // ena wea addra dina | enb web addrb dinb | cka xa | ckb xb | coll   (expectations for instance 0)
        tv[0]  = '{1, 1, 10'h005, 16'h1234, 0, 0, 10'h000, 16'h0000, 1, 16'h1234, 0, 16'h0000, 0};
        tv[1]  = '{0, 0, 10'h000, 16'h0000, 1, 0, 10'h005, 16'h0000, 1, 16'h1234, 1, 16'h1234, 0};
        tv[2]  = '{1, 1, 10'h020, 16'h0001, 0, 0, 10'h000, 16'h0000, 1, 16'h0001, 1, 16'h1234, 0};
        tv[3]  = '{1, 1, 10'h020, 16'h0F0F, 1, 0, 10'h020, 16'h0000, 1, 16'h0F0F, 1, 16'h0001, 0};
        tv[4]  = '{0, 0, 10'h000, 16'h0000, 1, 0, 10'h020, 16'h0000, 1, 16'h0F0F, 1, 16'h0F0F, 0};
        tv[5]  = '{1, 1, 10'h3FF, 16'hBEEF, 1, 1, 10'h3FF, 16'hDEAD, 1, 16'hBEEF, 1, 16'hDEAD, 1};
        tv[6]  = '{1, 0, 10'h3FF, 16'h0000, 0, 0, 10'h000, 16'h0000, 1, 16'hBEEF, 1, 16'hDEAD, 0};
        tv[7]  = '{0, 0, 10'h000, 16'h0000, 1, 0, 10'h3FF, 16'h0000, 1, 16'hBEEF, 1, 16'hBEEF, 0};
        tv[8]  = '{1, 1, 10'h3FF, 16'h1111, 1, 1, 10'h3FE, 16'h2222, 1, 16'h1111, 1, 16'h2222, 0};
        tv[9]  = '{1, 1, 10'h010, 16'h00AA, 0, 0, 10'h000, 16'h0000, 1, 16'h00AA, 1, 16'h2222, 0};
        tv[10] = '{1, 1, 10'h010, 16'h5555, 1, 0, 10'h010, 16'h0000, 1, 16'h5555, 1, 16'h00AA, 0};
        tv[11] = '{1, 0, 10'h010, 16'h0000, 1, 0, 10'h010, 16'h0000, 1, 16'h5555, 1, 16'h5555, 0};

        for (int j = 0; j < (1 << AW); j++) begin mm[j] = '0; mk[j] = 0; end
        rst = 1'b1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_douta[%0d]", i), douta_w[i], 0);
            chk($sformatf("rst_doutb[%0d]", i), doutb_w[i], 0);
            chk($sformatf("rst_coll[%0d]", i), coll_w[i], 0);
        end
        chk("rst_small_douta", douta3, 0);
`ifdef SAMP_RAM_INIT_CLEAR_EN
        chk("rst_busy", busy_w[0], 1);
        chk("rst_small_busy", busy3, 1);
`else
        chk("rst_busy", busy_w[0], 0);
        chk("rst_small_busy", busy3, 0);
`endif
        model_reset();
        rst = 1'b0;
        post_reset();

        for (int t = 0; t < 12; t++) begin
            drive(tv[t].ena, tv[t].wea, tv[t].addra, tv[t].dina, tv[t].enb, tv[t].web, tv[t].addrb, tv[t].dinb);
            step();
            if (tv[t].cka) chk($sformatf("vec%0d_douta", t), douta_w[0], tv[t].xa);
            if (tv[t].ckb) chk($sformatf("vec%0d_doutb", t), doutb_w[0], tv[t].xb);
            chk($sformatf("vec%0d_coll", t), coll_w[0], tv[t].xcoll);
        end
        chk("rf_old_data", douta_w[1], 16'h5555);

        // Two-cycle latency on the no-change instance, then enable-low hold.
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        step(); step();
        chk("lat2_settled", doutb_w[2], 16'h5555);
        drive(0, 0, '0, '0, 1, 0, 10'h005, '0);
        step();
        chk("lat2_edgeN", doutb_w[2], 16'h5555);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        step();
        chk("lat2_edgeN1", doutb_w[2], 16'h1234);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("lat2_hold%0d", c), doutb_w[2], 16'h1234);
        end

        for (int c = 0; c < 400; c++) begin
            int ra, rb;
            ra = $urandom_range(0, 15);
            rb = $urandom_range(0, 15);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  AW'(ra < 8 ? ra : 10'h3F0 + ra), DW'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  AW'(rb < 8 ? rb : 10'h3F0 + rb), DW'($urandom));
            step();
        end

        // Mid-operation reset: outputs clear asynchronously, memory is retained (or re-cleared).
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("arst_douta[%0d]", i), douta_w[i], 0);
            chk($sformatf("arst_doutb[%0d]", i), doutb_w[i], 0);
            chk($sformatf("arst_coll[%0d]", i), coll_w[i], 0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        post_reset();
        for (int c = 0; c < 16; c++) begin
            drive(1, 0, AW'(c < 8 ? c : 10'h3F0 + c), '0, 1, 0, AW'(c < 8 ? 7 - c : 10'h3F0 + 23 - c), '0);
            step();
        end
        drive(0, 0, '0, '0, 0, 0, '0, '0);

`ifdef SAMP_RAM_INIT_CLEAR_EN
        fill_small();
        rst = 1'b1;
        #1;
        chk("small_rst_busy", busy3, 1);
        chk("small_rst_douta", douta3, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_count(64, n);
        chk("small_clear_cycles", n, 16);
        read_all_small("clr");

        fill_small();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_count(8, n);
        chk("restart_mid_busy", busy3, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_count(64, n);
        chk("restart_clear_cycles", n, 16);
        read_all_small("rclr");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
